tv_checker: RTL and testbench

TV_CHECKER -- requirements
Module: tv_checker

---
 rtl/tv_checker_pkg.sv | 24 ++
 rtl/tv_checker_if.sv | 43 ++++
 rtl/tv_mem.sv | 37 +++
 rtl/tv_checker.sv | 159 +++++++++++++++
 tb/tb_tv_checker.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tv_checker_pkg.sv
// Shared types and constants for the test-vector checker.
// TV_CHECKER_MASK_EN widens each vector with a per-bit compare mask.
package tv_checker_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        APPLY = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Vector word width: {stimulus, expected[, mask]}, stimulus in the MSBs.
    function automatic int vw_calc(input int in_w, input int out_w);
`ifdef TV_CHECKER_MASK_EN
        return in_w + 2 * out_w;
`else
        return in_w + out_w;
`endif
    endfunction

endpackage

// File: rtl/tv_checker_if.sv
// Bundle of run control, vector load, DUT drive/response and result signals.
// Vector width follows TV_CHECKER_MASK_EN through tv_checker_pkg::vw_calc.
interface tv_checker_if
    import tv_checker_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 56,
    parameter int DEPTH = 2048
) ();

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int VW = vw_calc(IN_W, OUT_W);

    // Level signals, sampled on the rising clock; start is a one-cycle request
    // honoured only while busy=0, and ld_we writes only while busy=0.
    logic                 start;
    logic [NW-1:0]        num_vec;
    logic                 ld_we;
    logic [AW-1:0]        ld_addr;
    logic [VW-1:0]        ld_data;
    logic [IN_W-1:0]      stim;
    logic [OUT_W-1:0]     dut_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [AW-1:0]        vec_idx;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_stb;
    logic [OUT_W-1:0]     err_got;
    logic [OUT_W-1:0]     err_exp;

    modport master (
        output start, num_vec, ld_we, ld_addr, ld_data, dut_out,
        input  stim, busy, done, pass, vec_idx, err_cnt, err_stb, err_got, err_exp
    );

    modport slave (
        input  start, num_vec, ld_we, ld_addr, ld_data, dut_out,
        output stim, busy, done, pass, vec_idx, err_cnt, err_stb, err_got, err_exp
    );

endinterface

// File: rtl/tv_mem.sv
// Single-port synchronous vector RAM, one-cycle read latency.
// Array contents survive reset; only the read register is cleared.
module tv_mem #(
    parameter int DEPTH = 2048,
    parameter int VW    = 74,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [VW-1:0] i_wdata,
    output logic [VW-1:0] o_rdata
);

    logic [VW-1:0] r_mem [DEPTH];
    logic [VW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register doubles as the held stimulus/expected word between fetches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tv_checker.sv
// Test-vector checker: applies stored stimuli, waits SETTLE clocks, compares responses.
// Define TV_CHECKER_MASK_EN to compare only the bits selected by a per-vector mask.
module tv_checker
    import tv_checker_pkg::*;
#(
    parameter int IN_W   = 18,
    parameter int OUT_W  = 56,
    parameter int DEPTH  = 2048,
    parameter int SETTLE = 4096
) (
    input  logic   clk,
    input  logic   rst_n,
    tv_checker_if.slave bus,
    output state_t o_dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int VW = vw_calc(IN_W, OUT_W);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t               r_state;
    logic [AW-1:0]        r_vec_idx;
    logic [NW-1:0]        r_num_vec;
    logic [SW-1:0]        r_settle;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_err_stb;
    logic [OUT_W-1:0]     r_err_got;
    logic [OUT_W-1:0]     r_err_exp;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic [VW-1:0]        w_rdata;
    logic [AW-1:0]        w_mem_addr;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [NW-1:0]        w_num_clamp;
    logic [OUT_W-1:0]     w_exp;
    logic                 w_mismatch;
    logic                 w_last;

    assign w_mem_re   = (r_state == FETCH);
    assign w_mem_we   = bus.ld_we && !r_busy;
    assign w_mem_addr = w_mem_re ? r_vec_idx : bus.ld_addr;

    tv_mem #(
        .DEPTH (DEPTH),
        .VW    (VW),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (bus.ld_data),
        .o_rdata (w_rdata)
    );

    // The RAM read register holds the word from FETCH until the next FETCH,
    // so the stimulus is stable for the whole APPLY/CHECK window.
    assign bus.stim = w_rdata[VW-1 -: IN_W];

`ifdef TV_CHECKER_MASK_EN
    logic [OUT_W-1:0] w_mask;
    assign w_mask     = w_rdata[OUT_W-1:0];
    assign w_exp      = w_rdata[2*OUT_W-1:OUT_W];
    assign w_mismatch = |((bus.dut_out ^ w_exp) & w_mask);
`else
    assign w_exp      = w_rdata[OUT_W-1:0];
    assign w_mismatch = (bus.dut_out != w_exp);
`endif

    assign w_num_clamp = (bus.num_vec > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_vec;
    assign w_last      = ((NW'(r_vec_idx) + NW'(1)) == r_num_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vec_idx <= '0;
            r_num_vec <= '0;
            r_settle  <= '0;
            r_err_cnt <= '0;
            r_err_stb <= 1'b0;
            r_err_got <= '0;
            r_err_exp <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_err_stb <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_vec_idx <= '0;
                        r_err_cnt <= '0;
                        r_num_vec <= w_num_clamp;
                        if (w_num_clamp == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    r_state  <= APPLY;
                    r_settle <= SW'(SETTLE - 1);
                end
                APPLY: begin
                    if (r_settle == '0) begin
                        r_state <= CHECK;
                    end else begin
                        r_settle <= r_settle - SW'(1);
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        r_err_stb <= 1'b1;
                        r_err_got <= bus.dut_out;
                        r_err_exp <= w_exp;
                        if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                        end
                    end
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_cnt == '0) && !w_mismatch;
                    end else begin
                        r_state   <= FETCH;
                        r_vec_idx <= r_vec_idx + AW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.vec_idx = r_vec_idx;
    assign bus.err_cnt = r_err_cnt;
    assign bus.err_stb = r_err_stb;
    assign bus.err_got = r_err_got;
    assign bus.err_exp = r_err_exp;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tv_checker.sv
// Directed bench for tv_checker; the modelled DUT returns the zero-extended stimulus
// XOR a per-test flip pattern, so expected fields are known by hand.
module tb_tv_checker;
    import tv_checker_pkg::*;

    localparam int IN_W   = 18;
    localparam int OUT_W  = 56;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 4;
    localparam int VW     = vw_calc(IN_W, OUT_W);
    localparam int AW     = $clog2(DEPTH);
    localparam int NW     = $clog2(DEPTH + 1);
    localparam int VEC_CYC = 1 + SETTLE + 1;
    localparam logic [OUT_W-1:0] ALL1 = {OUT_W{1'b1}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tv_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();
    state_t dbg_state;
    logic [OUT_W-1:0] r_flip = '0;

    assign bus.dut_out = {{(OUT_W-IN_W){1'b0}}, bus.stim} ^ r_flip;

    tv_checker #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- scoreboard ----------------
    logic [OUT_W-1:0] got_q[$];
    logic [OUT_W-1:0] gexp_q[$];
    logic [OUT_W-1:0] exp_q[$];
    int busy_cycles = 0;

    always @(negedge clk) begin
        if (bus.err_stb === 1'b1) begin
            got_q.push_back(bus.err_got);
            gexp_q.push_back(bus.err_exp);
        end
        if (bus.busy === 1'b1) busy_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input int addr, input logic [IN_W-1:0] s,
                            input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] m);
        bus.ld_addr = AW'(addr);
`ifdef TV_CHECKER_MASK_EN
        bus.ld_data = {s, e, m};
`else
        bus.ld_data = {s, e};
`endif
        bus.ld_we = 1'b1;
        step();
        bus.ld_we = 1'b0;
    endtask

    task automatic pulse_start(input int num);
        bus.num_vec = NW'(num);
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(inout int cycles);
        while (bus.done !== 1'b1 && cycles < 2000) begin
            step();
            cycles++;
        end
    endtask

    task automatic load_pass_set();
        load_vec(0, 18'h00012, 56'h12, ALL1);
        load_vec(1, 18'h2A5A5, 56'h2A5A5, ALL1);
        load_vec(2, 18'h3FFFF, 56'h3FFFF, ALL1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
        n_tests++; if (bus.stim !== '0) begin n_fail++; $display("FAIL reset_stim got %h exp 0", bus.stim); end
        n_tests++; if (bus.vec_idx !== '0) begin n_fail++; $display("FAIL reset_vec_idx got %h exp 0", bus.vec_idx); end
        n_tests++; if (bus.err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt got %h exp 0", bus.err_cnt); end
        n_tests++; if ({bus.busy, bus.done, bus.pass, bus.err_stb} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {bus.busy, bus.done, bus.pass, bus.err_stb}); end
        n_tests++; if ({bus.err_got, bus.err_exp} !== '0) begin n_fail++; $display("FAIL reset_err_data got %h exp 0", {bus.err_got, bus.err_exp}); end
        step(); step();
        rst_n = 1'b1;
        step();
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL post_reset_state got %0d exp %0d", dbg_state, IDLE); end
    endtask

    task automatic test_zero_vec();
        int b0 = busy_cycles;
        int cyc = 0;
        pulse_start(0);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b exp 1", bus.done); end
        n_tests++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL zero_pass got %b exp 1", bus.pass); end
        n_tests++; if (bus.err_cnt !== '0) begin n_fail++; $display("FAIL zero_err_cnt got %0d exp 0", bus.err_cnt); end
        step(); step();
        cyc = busy_cycles - b0;
        n_tests++; if (cyc != 0) begin n_fail++; $display("FAIL zero_busy got %0d busy cycles exp 0", cyc); end
    endtask

    task automatic test_basic_pass();
        int cyc = 0;
        int base;
        load_pass_set();
        base = got_q.size();
        pulse_start(3);
        wait_done(cyc);
        n_tests++; if (cyc != 3 * VEC_CYC) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", cyc, 3 * VEC_CYC); end
        n_tests++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL basic_pass got %b exp 1", bus.pass); end
        n_tests++; if (bus.err_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_err_cnt got %0d exp 0", bus.err_cnt); end
        n_tests++; if (bus.vec_idx !== AW'(2)) begin n_fail++; $display("FAIL basic_vec_idx got %0d exp 2", bus.vec_idx); end
        step();
        n_tests++; if (got_q.size() != base) begin n_fail++; $display("FAIL basic_no_stb got %0d strobes exp 0", got_q.size() - base); end
    endtask

    task automatic check_err_run(input string name, input int base, input int cyc);
        n_tests++; if (cyc != 3 * VEC_CYC) begin n_fail++; $display("FAIL %s_latency got %0d exp %0d", name, cyc, 3 * VEC_CYC); end
        n_tests++; if (bus.err_cnt !== 16'd1) begin n_fail++; $display("FAIL %s_err_cnt got %0d exp 1", name, bus.err_cnt); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL %s_pass got %b exp 0", name, bus.pass); end
        n_tests++; if (got_q.size() != base + 1) begin n_fail++; $display("FAIL %s_stb_count got %0d exp 1", name, got_q.size() - base); end
        if (got_q.size() == base + 1) begin
            n_tests++; if (got_q[base] !== exp_q[0]) begin n_fail++; $display("FAIL %s_err_got got %h exp %h", name, got_q[base], exp_q[0]); end
            n_tests++; if (gexp_q[base] !== 56'h0) begin n_fail++; $display("FAIL %s_err_exp got %h exp 0", name, gexp_q[base]); end
        end
    endtask

    task automatic test_mismatch();
        int cyc = 0;
        int base;
        load_vec(1, 18'h00001, 56'h0, ALL1);
        exp_q.delete();
        exp_q.push_back(56'h1);
        base = got_q.size();
        pulse_start(3);
        wait_done(cyc);
        step();
        check_err_run("mismatch", base, cyc);
    endtask

    task automatic test_start_busy();
        int cyc = 0;
        pulse_start(3);
        step(); step(); cyc = 2;
        bus.num_vec = '0;
        bus.start = 1'b1;
        step(); cyc++;
        bus.start = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_busy_still_busy got %b exp 1", bus.busy); end
        wait_done(cyc);
        n_tests++; if (cyc != 3 * VEC_CYC) begin n_fail++; $display("FAIL start_busy_latency got %0d exp %0d", cyc, 3 * VEC_CYC); end
    endtask

    task automatic test_write_busy();
        int cyc = 0;
        int base = got_q.size();
        pulse_start(3);
        step(); cyc = 1;
        bus.ld_addr = '0;
        bus.ld_data = '1;
        bus.ld_we   = 1'b1;
        step(); cyc++;
        bus.ld_we   = 1'b0;
        wait_done(cyc);
        step();
        check_err_run("write_busy", base, cyc);
    endtask

    task automatic test_reset_mid_run();
        int cyc = 0;
        int base;
        pulse_start(3);
        while (!(bus.vec_idx === AW'(2) && dbg_state === APPLY) && cyc < 200) begin
            step();
            cyc++;
        end
        n_tests++; if (dbg_state !== APPLY || bus.err_cnt !== 16'd1) begin n_fail++; $display("FAIL midrun_reach got state %0d err_cnt %0d exp APPLY/1", dbg_state, bus.err_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({bus.stim, bus.vec_idx, bus.err_cnt} !== '0) begin n_fail++; $display("FAIL midrun_rst_data got %h exp 0", {bus.stim, bus.vec_idx, bus.err_cnt}); end
        n_tests++; if ({bus.busy, bus.done, bus.pass, bus.err_stb} !== 4'b0) begin n_fail++; $display("FAIL midrun_rst_flags got %b exp 0000", {bus.busy, bus.done, bus.pass, bus.err_stb}); end
        n_tests++; if ({bus.err_got, bus.err_exp} !== '0) begin n_fail++; $display("FAIL midrun_rst_err got %h exp 0", {bus.err_got, bus.err_exp}); end
        step(); step();
        rst_n = 1'b1;
        base = got_q.size();
        step(); step(); step(); step();
        n_tests++; if (got_q.size() != base) begin n_fail++; $display("FAIL midrun_stb_after_rst got %0d exp 0", got_q.size() - base); end
        // only vector 1 is rewritten; vectors 0 and 2 must have survived reset
        load_vec(1, 18'h2A5A5, 56'h2A5A5, ALL1);
        pulse_start(3);
        n_tests++; if (dbg_state !== FETCH || bus.vec_idx !== '0) begin n_fail++; $display("FAIL restart_fetch got state %0d idx %0d exp FETCH/0", dbg_state, bus.vec_idx); end
        step(); cyc = 1;
        n_tests++; if (bus.stim !== 18'h00012) begin n_fail++; $display("FAIL restart_stim got %h exp 00012", bus.stim); end
        wait_done(cyc);
        n_tests++; if (cyc != 3 * VEC_CYC || bus.pass !== 1'b1) begin n_fail++; $display("FAIL restart_run got cyc %0d pass %b exp %0d/1", cyc, bus.pass, 3 * VEC_CYC); end
    endtask

    task automatic test_clamp();
        int cyc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [IN_W-1:0] s;
            s = IN_W'(i * 18'h1111 + 3);
            load_vec(i, s, {{(OUT_W-IN_W){1'b0}}, s}, ALL1);
        end
        pulse_start(DEPTH + 4);
        wait_done(cyc);
        n_tests++; if (cyc != DEPTH * VEC_CYC) begin n_fail++; $display("FAIL clamp_latency got %0d exp %0d", cyc, DEPTH * VEC_CYC); end
        n_tests++; if (bus.vec_idx !== AW'(DEPTH - 1)) begin n_fail++; $display("FAIL clamp_vec_idx got %0d exp %0d", bus.vec_idx, DEPTH - 1); end
        n_tests++; if (bus.pass !== 1'b1 || bus.err_cnt !== 16'd0) begin n_fail++; $display("FAIL clamp_result got pass %b err %0d exp 1/0", bus.pass, bus.err_cnt); end
    endtask

    task automatic test_compare_bits();
        int cyc;
        int base;
`ifdef TV_CHECKER_MASK_EN
        logic [15:0]      exp_cnt20 = 16'd0;
        logic [OUT_W-1:0] exp_got20 = 56'h0;
`else
        logic [15:0]      exp_cnt20 = 16'd1;
        logic [OUT_W-1:0] exp_got20 = 56'h100055;
`endif
        load_vec(0, 18'h00055, 56'h55, 56'hFF);
        // bit 20: outside the mask when masking is built in
        r_flip = 56'h1 << 20;
        base = got_q.size();
        cyc = 0;
        pulse_start(1);
        wait_done(cyc);
        step();
        n_tests++; if (cyc != VEC_CYC || bus.err_cnt !== exp_cnt20) begin n_fail++; $display("FAIL bit20_err_cnt got %0d cyc %0d exp %0d/%0d", bus.err_cnt, cyc, exp_cnt20, VEC_CYC); end
        n_tests++; if (got_q.size() != base + int'(exp_cnt20)) begin n_fail++; $display("FAIL bit20_stb got %0d exp %0d", got_q.size() - base, exp_cnt20); end
        if (exp_cnt20 == 16'd1 && got_q.size() == base + 1) begin
            n_tests++; if (got_q[base] !== exp_got20) begin n_fail++; $display("FAIL bit20_err_got got %h exp %h", got_q[base], exp_got20); end
        end
        // bit 3: inside the mask, always an error
        r_flip = 56'h8;
        base = got_q.size();
        cyc = 0;
        pulse_start(1);
        wait_done(cyc);
        step();
        n_tests++; if (bus.err_cnt !== 16'd1 || bus.pass !== 1'b0) begin n_fail++; $display("FAIL bit3_result got err %0d pass %b exp 1/0", bus.err_cnt, bus.pass); end
        n_tests++; if (got_q.size() != base + 1) begin n_fail++; $display("FAIL bit3_stb got %0d exp 1", got_q.size() - base); end
        if (got_q.size() == base + 1) begin
            n_tests++; if (got_q[base] !== 56'h5D || gexp_q[base] !== 56'h55) begin n_fail++; $display("FAIL bit3_err_data got %h/%h exp 5d/55", got_q[base], gexp_q[base]); end
        end
        r_flip = '0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        bus.start   = 1'b0;
        bus.num_vec = '0;
        bus.ld_we   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        test_reset();
        test_zero_vec();
        test_basic_pass();
        test_mismatch();
        test_start_busy();
        test_write_busy();
        test_reset_mid_run();
        test_clamp();
        test_compare_bits();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
